// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and decode constants for the CPU bus sequencer
package bus_pkg;

  typedef enum logic [1:0] {
    DEV_MEM,
    DEV_IO,
    DEV_HYP
  } dev_t;

  typedef enum logic [2:0] {
    S_WAIT,
    S_BUS,
    S_P1,
    S_P2,
    S_DMA
  } state_t;

  localparam logic [19:0] IO_PORT_ADDR = 20'h0BFFC;
  localparam logic [13:0] HYP_PAGE     = {12'h0D6, 2'b01};

  // Wait states inserted before the bus window of an access to device d.
  function automatic logic [3:0] dev_wait(input dev_t d,
                                          input logic [3:0] mem_w,
                                          input logic [3:0] io_w,
                                          input logic [3:0] hyp_w);
    logic [3:0] w;
    case (d)
      DEV_IO:  w = io_w;
      DEV_HYP: w = hyp_w;
      default: w = mem_w;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// rtl/bus_addr_decode.sv - CPU address to device select decode (IO > HYP > MEM)
module bus_addr_decode
  import bus_pkg::*;
(
  input  logic [19:0] cpu_address,
  output logic        io_cs,
  output logic        hyp_cs,
  output dev_t        device
);

  // IO port is a single address; hypervisor registers occupy one 64-byte page.
  always_comb begin
    io_cs  = (cpu_address == IO_PORT_ADDR);
    hyp_cs = ~io_cs & (cpu_address[19:6] == HYP_PAGE);
    if (io_cs) begin
      device = DEV_IO;
    end else if (hyp_cs) begin
      device = DEV_HYP;
    end else begin
      device = DEV_MEM;
    end
  end

endmodule

// File: rtl/cpu_bus_sequencer.sv
// rtl/cpu_bus_sequencer.sv - phi3/phi1/phi2 bus phasing, wait states, read mux and DMA arbitration
module cpu_bus_sequencer
  import bus_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned IO_WAIT  = 1,
  parameter int unsigned HYP_WAIT = 0,
  parameter int unsigned DMA_MAX  = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ext_ready,
  input  logic [19:0] cpu_address,
  input  logic        cpu_write,
  input  logic [7:0]  mem_data_i,
  input  logic [7:0]  io_data_i,
  input  logic [7:0]  hyp_data_i,
  input  logic        dma_req,
  output logic        phi1,
  output logic        phi2,
  output logic        phi3,
  output logic        mem_we,
  output logic        io_cs,
  output logic        hyp_cs,
  output logic [7:0]  cpu_data_i,
  output logic        dma_gnt
);

  localparam logic [3:0] MEM_W   = 4'(MEM_WAIT);
  localparam logic [3:0] IO_W    = 4'(IO_WAIT);
  localparam logic [3:0] HYP_W   = 4'(HYP_WAIT);
  localparam logic [7:0] DMA_LIM = 8'(DMA_MAX - 1);

  state_t     state;
  dev_t       dec_dev;
  dev_t       bus_device;
  logic [3:0] wait_cnt;
  logic [7:0] dma_cnt;
  logic       force_cpu;
  logic [3:0] dec_wait;

  bus_addr_decode u_decode (
    .cpu_address (cpu_address),
    .io_cs       (io_cs),
    .hyp_cs      (hyp_cs),
    .device      (dec_dev)
  );

  assign dec_wait = dev_wait(dec_dev, MEM_W, IO_W, HYP_W);

  // The bus window is open only in S_BUS with the system ready; held low throughout reset.
  assign phi3   = reset_n & ext_ready & (state == S_BUS);
  assign mem_we = cpu_write & phi3 & ~io_cs & ~hyp_cs;

  // Return data from the device latched during the last bus window.
  always_comb begin
    case (bus_device)
      DEV_IO:  cpu_data_i = io_data_i;
      DEV_HYP: cpu_data_i = hyp_data_i;
      default: cpu_data_i = mem_data_i;
    endcase
  end

  // Sequencer: phase generation, wait insertion and DMA hand-over; phi1/phi2/dma_gnt track the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_BUS;
      phi1       <= 1'b0;
      phi2       <= 1'b0;
      dma_gnt    <= 1'b0;
      wait_cnt   <= 4'd0;
      dma_cnt    <= 8'd0;
      force_cpu  <= 1'b0;
      bus_device <= DEV_MEM;
    end else begin
      phi1    <= 1'b0;
      phi2    <= 1'b0;
      dma_gnt <= 1'b0;
      if (phi3) begin
        bus_device <= dec_dev;
      end
      case (state)
        S_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt <= 4'd1) begin
            wait_cnt <= 4'd0;
            state    <= S_BUS;
          end
        end
        S_BUS: begin
          if (ext_ready) begin
            state <= S_P1;
            phi1  <= 1'b1;
          end
        end
        S_P1: begin
          state <= S_P2;
          phi2  <= 1'b1;
        end
        S_P2: begin
          // Wait states of the next access are remembered even when DMA takes the bus first.
          wait_cnt <= dec_wait;
          if (dma_req && !force_cpu) begin
            state   <= S_DMA;
            dma_gnt <= 1'b1;
          end else begin
            force_cpu <= 1'b0;
            state     <= (dec_wait != 4'd0) ? S_WAIT : S_BUS;
          end
        end
        S_DMA: begin
          if (!dma_req || dma_cnt == DMA_LIM) begin
            if (dma_cnt == DMA_LIM) begin
              force_cpu <= 1'b1;
            end
            dma_cnt <= 8'd0;
            state   <= (wait_cnt != 4'd0) ? S_WAIT : S_BUS;
          end else begin
            dma_cnt <= dma_cnt + 8'd1;
            dma_gnt <= 1'b1;
          end
        end
        default: begin
          state <= S_BUS;
        end
      endcase
    end
  end

endmodule
